// File: rtl/heap_requester_pkg.sv
// Shared definitions for the heap requester: default address width,
// FSM state encodings and the grant-history type.
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif

package heap_requester_pkg;

    localparam int DEF_ADDR_BITS = `ADDRESS_BITS;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_ALLOC = 2'd1;
    localparam logic [1:0] ST_WAIT_FREE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE       = ST_IDLE,
        WAIT_ALLOC = ST_WAIT_ALLOC,
        WAIT_FREE  = ST_WAIT_FREE
    } state_t;

    typedef enum logic {
        GRANT_ALLOC = 1'b0,
        GRANT_FREE  = 1'b1
    } grant_t;

endpackage

// File: rtl/heap_free_fifo.sv
// Pending-free address FIFO.
// Ports: clk, reset (async active-low), push/data in, pop, full, empty, head.
module heap_free_fifo #(
    parameter int ADDR_BITS  = 8,
    parameter int FREE_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [ADDR_BITS-1:0] data,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS-1:0] head
);

    localparam int PW = $clog2(FREE_DEPTH);

    logic [ADDR_BITS-1:0] mem [FREE_DEPTH];
    logic [PW-1:0]        wr;
    logic [PW-1:0]        rd;
    logic [PW:0]          count;
    logic                 doPush;
    logic                 doPop;

    assign full   = (count == (PW+1)'(FREE_DEPTH));
    assign empty  = (count == '0);
    assign head   = mem[rd];
    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wr] <= data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wr <= wr + 1'b1;
            end
            if (doPop) begin
                rd <= rd + 1'b1;
            end
            unique case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/heap_requester.sv
// Arbitrates client alloc/free requests onto a single-operation heap port.
// Ports: client alloc/free handshakes, heap strobes and results, liveCount, freeUnderflow.
module heap_requester
    import heap_requester_pkg::*;
#(
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int FREE_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reqAlloc,
    output logic                 reqAllocReady,
    output logic                 allocValid,
    output logic [ADDR_BITS-1:0] allocAddr,
    input  logic                 reqFree,
    input  logic [ADDR_BITS-1:0] reqFreeAddr,
    output logic                 reqFreeReady,
    output logic                 heapAlloc,
    output logic                 heapFree,
    output logic [ADDR_BITS-1:0] heapFreeAddress,
    input  logic [ADDR_BITS-1:0] heapAllocAddress,
    input  logic                 heapFinished,
    output logic [ADDR_BITS:0]   liveCount,
    output logic                 freeUnderflow
);

    state_t               state;
    grant_t               lastGrant;
    logic                 allocPending;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [ADDR_BITS-1:0] fifoHead;
    logic                 allocAccept;
    logic                 freeAccept;
    logic                 grantFree;
    logic                 grantAlloc;
    logic                 fifoPop;

    assign reqAllocReady = !allocPending;
    assign reqFreeReady  = !fifoFull;
    assign allocAccept   = reqAlloc && reqAllocReady;
    assign freeAccept    = reqFree && reqFreeReady;

    // When both are pending, take the one not granted last time.
    assign grantFree  = !fifoEmpty &&
                        (!allocPending || lastGrant == GRANT_ALLOC);
    assign grantAlloc = allocPending &&
                        (fifoEmpty || lastGrant == GRANT_FREE);
    assign fifoPop    = (state == IDLE) && grantFree;

    heap_free_fifo #(
        .ADDR_BITS  (ADDR_BITS),
        .FREE_DEPTH (FREE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (freeAccept),
        .data  (reqFreeAddr),
        .pop   (fifoPop),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .head  (fifoHead)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            lastGrant       <= GRANT_ALLOC;
            allocPending    <= 1'b0;
            heapAlloc       <= 1'b0;
            heapFree        <= 1'b0;
            heapFreeAddress <= '0;
            allocAddr       <= '0;
            allocValid      <= 1'b0;
            liveCount       <= '0;
            freeUnderflow   <= 1'b0;
        end else begin
            heapAlloc  <= 1'b0;
            heapFree   <= 1'b0;
            allocValid <= 1'b0;
            if (allocAccept) begin
                allocPending <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (grantFree) begin
                        state           <= WAIT_FREE;
                        heapFree        <= 1'b1;
                        heapFreeAddress <= fifoHead;
                        lastGrant       <= GRANT_FREE;
                    end else if (grantAlloc) begin
                        state     <= WAIT_ALLOC;
                        heapAlloc <= 1'b1;
                        lastGrant <= GRANT_ALLOC;
                    end
                end
                WAIT_ALLOC: begin
                    if (heapFinished) begin
                        allocAddr    <= heapAllocAddress;
                        allocValid   <= 1'b1;
                        allocPending <= 1'b0;
                        liveCount    <= liveCount + 1'b1;
                        state        <= IDLE;
                    end
                end
                WAIT_FREE: begin
                    if (heapFinished) begin
                        if (liveCount == '0) begin
                            freeUnderflow <= 1'b1;
                        end else begin
                            liveCount <= liveCount - 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_heap_requester.sv
// Self-checking bench for heap_requester: vector table, heap model,
// and scoreboard queues for allocated and freed addresses.
module tb_heap_requester;

    localparam int AW = 8;

    typedef struct {
        bit          do_alloc;
        bit          do_free;
        logic [AW-1:0] free_addr;
        logic [AW-1:0] heap_addr;
        logic [AW:0]   exp_live;
        bit          exp_under;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          reqAlloc = 1'b0;
    logic          reqFree = 1'b0;
    logic [AW-1:0] reqFreeAddr = '0;
    logic          heapFinished = 1'b0;
    logic [AW-1:0] heapAllocAddress = '0;
    logic          reqAllocReady;
    logic          allocValid;
    logic [AW-1:0] allocAddr;
    logic          reqFreeReady;
    logic          heapAlloc;
    logic          heapFree;
    logic [AW-1:0] heapFreeAddress;
    logic [AW:0]   liveCount;
    logic          freeUnderflow;

    int nchecks = 0;
    int nfail = 0;

    logic [AW-1:0] exp_alloc[$];
    logic [AW-1:0] exp_free[$];
    logic [AW-1:0] heap_addrs[$];
    int            strobe_log[$];
    bit            hold = 1'b0;
    bit            busy = 1'b0;
    bit            is_alloc = 1'b0;
    bit            prev_strobe = 1'b0;
    logic [AW-1:0] inflight_addr = '0;

    heap_requester dut (
        .clk              (clk),
        .reset            (rst_n),
        .reqAlloc         (reqAlloc),
        .reqAllocReady    (reqAllocReady),
        .allocValid       (allocValid),
        .allocAddr        (allocAddr),
        .reqFree          (reqFree),
        .reqFreeAddr      (reqFreeAddr),
        .reqFreeReady     (reqFreeReady),
        .heapAlloc        (heapAlloc),
        .heapFree         (heapFree),
        .heapFreeAddress  (heapFreeAddress),
        .heapAllocAddress (heapAllocAddress),
        .heapFinished     (heapFinished),
        .liveCount        (liveCount),
        .freeUnderflow    (freeUnderflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Heap model and scoreboard; answers each strobe one cycle later.
    always @(posedge clk) begin
        #1;
        if (heapFinished) heapFinished = 1'b0;
        if (!rst_n) begin
            busy = 1'b0;
            prev_strobe = 1'b0;
        end else begin
            if (allocValid) begin
                if (exp_alloc.size() == 0) begin
                    nchecks++;
                    nfail++;
                    $display("FAIL unexpected_allocValid: got addr 0x%0h, expected none",
                             allocAddr);
                end else begin
                    check("allocAddr", 32'(allocAddr), 32'(exp_alloc.pop_front()));
                end
            end
            if (heapAlloc || heapFree) begin
                check("strobe_exclusive", 32'(heapAlloc && heapFree), 0);
                check("strobe_one_cycle", 32'(prev_strobe), 0);
                strobe_log.push_back(heapFree ? 2 : 1);
                if (heapFree) begin
                    if (exp_free.size() == 0) begin
                        nchecks++;
                        nfail++;
                        $display("FAIL unexpected_heapFree: got addr 0x%0h, expected none",
                                 heapFreeAddress);
                    end else begin
                        check("heapFreeAddress", 32'(heapFreeAddress),
                              32'(exp_free.pop_front()));
                    end
                    inflight_addr = heapFreeAddress;
                end
                busy = 1'b1;
                is_alloc = heapAlloc;
            end else if (busy && !hold) begin
                if (!is_alloc)
                    check("freeAddr_stable", 32'(heapFreeAddress), 32'(inflight_addr));
                heapAllocAddress = (is_alloc && heap_addrs.size() > 0) ?
                                   heap_addrs.pop_front() : '0;
                heapFinished = 1'b1;
                busy = 1'b0;
            end
            prev_strobe = heapAlloc || heapFree;
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_alloc.size() != 0 || exp_free.size() != 0 || busy ||
                heapFinished) && n < 40) begin
            tick;
            n++;
        end
        check({name, "_timeout"}, 32'(n < 40), 1);
        tick;
        tick;
    endtask

    initial begin
        vec_t vecs[10];
        int n;
        vecs[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 9'd1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h10, 8'h00, 9'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 8'h3C, 9'd1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 8'h41, 9'd2, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 8'h20, 8'h55, 9'd2, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'h3C, 8'h00, 9'd1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 8'h41, 8'h00, 9'd0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 8'h05, 8'h00, 9'd0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 8'h00, 8'h7F, 9'd1, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 8'h55, 8'h00, 9'd0, 1'b1};

        repeat (3) @(posedge clk);
        #2;
        check("rst_reqAllocReady", 32'(reqAllocReady), 1);
        check("rst_reqFreeReady", 32'(reqFreeReady), 1);
        check("rst_allocValid", 32'(allocValid), 0);
        check("rst_allocAddr", 32'(allocAddr), 0);
        check("rst_heapAlloc", 32'(heapAlloc), 0);
        check("rst_heapFree", 32'(heapFree), 0);
        check("rst_heapFreeAddress", 32'(heapFreeAddress), 0);
        check("rst_liveCount", 32'(liveCount), 0);
        check("rst_freeUnderflow", 32'(freeUnderflow), 0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 10; i++) begin
            strobe_log.delete();
            if (vecs[i].do_alloc) begin
                heap_addrs.push_back(vecs[i].heap_addr);
                exp_alloc.push_back(vecs[i].heap_addr);
            end
            if (vecs[i].do_free) exp_free.push_back(vecs[i].free_addr);
            reqAlloc = vecs[i].do_alloc;
            reqFree = vecs[i].do_free;
            reqFreeAddr = vecs[i].free_addr;
            tick;
            reqAlloc = 1'b0;
            reqFree = 1'b0;
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_liveCount", i), 32'(liveCount),
                  32'(vecs[i].exp_live));
            check($sformatf("vec%0d_freeUnderflow", i), 32'(freeUnderflow),
                  32'(vecs[i].exp_under));
            check($sformatf("vec%0d_strobes", i), 32'(strobe_log.size()),
                  32'(int'(vecs[i].do_alloc) + int'(vecs[i].do_free)));
            check($sformatf("vec%0d_allocReady", i), 32'(reqAllocReady), 1);
            if (vecs[i].do_alloc && vecs[i].do_free && strobe_log.size() == 2) begin
                check("contention_first_free", 32'(strobe_log[0]), 2);
                check("contention_then_alloc", 32'(strobe_log[1]), 1);
            end
        end

        // Completion seen while idle must change nothing.
        strobe_log.delete();
        @(negedge clk);
        heapAllocAddress = 8'hEE;
        heapFinished = 1'b1;
        tick;
        tick;
        check("idle_finish_live", 32'(liveCount), 0);
        check("idle_finish_strobes", 32'(strobe_log.size()), 0);
        check("idle_finish_allocAddr", 32'(allocAddr), 32'h7F);

        // FIFO fill while the heap stalls.
        strobe_log.delete();
        hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            reqFree = 1'b1;
            reqFreeAddr = AW'(8'hA0 + i);
            check($sformatf("fifo_ready_%0d", i), 32'(reqFreeReady), 32'(i < 5));
            if (i < 5) exp_free.push_back(AW'(8'hA0 + i));
            tick;
        end
        reqFree = 1'b0;
        check("fifo_full_blocked", 32'(reqFreeReady), 0);
        check("fifo_one_in_flight", 32'(strobe_log.size()), 1);
        hold = 1'b0;
        wait_idle("fifo_drain");
        check("fifo_drain_strobes", 32'(strobe_log.size()), 5);
        check("fifo_drain_ready", 32'(reqFreeReady), 1);
        check("fifo_drain_live", 32'(liveCount), 0);
        check("fifo_drain_under", 32'(freeUnderflow), 1);

        // Reset while an alloc is outstanding.
        strobe_log.delete();
        hold = 1'b1;
        heap_addrs.push_back(8'h99);
        reqAlloc = 1'b1;
        tick;
        reqAlloc = 1'b0;
        n = 0;
        while (strobe_log.size() == 0 && n < 10) begin
            tick;
            n++;
        end
        check("midop_strobe_seen", 32'(n < 10), 1);
        tick;
        check("midop_pending", 32'(reqAllocReady), 0);
        rst_n = 1'b0;
        #1;
        check("midop_rst_allocReady", 32'(reqAllocReady), 1);
        check("midop_rst_freeReady", 32'(reqFreeReady), 1);
        check("midop_rst_heapAlloc", 32'(heapAlloc), 0);
        check("midop_rst_allocAddr", 32'(allocAddr), 0);
        check("midop_rst_live", 32'(liveCount), 0);
        check("midop_rst_under", 32'(freeUnderflow), 0);
        heap_addrs.delete();
        hold = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        strobe_log.delete();
        repeat (6) tick;
        check("midop_no_strobes", 32'(strobe_log.size()), 0);
        check("midop_allocValid", 32'(allocValid), 0);

        // Block recovers normally after reset.
        heap_addrs.push_back(8'h12);
        exp_alloc.push_back(8'h12);
        reqAlloc = 1'b1;
        tick;
        reqAlloc = 1'b0;
        wait_idle("recover");
        check("recover_live", 32'(liveCount), 1);
        check("recover_allocAddr", 32'(allocAddr), 32'h12);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchecks, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/heap_requester.md
HEAP_REQUESTER -- requirements
Module: heap_requester

Interface
REQ-001 Parameter ADDR_BITS, default `ADDRESS_BITS (8), width of every heap address.
REQ-002 Parameter FREE_DEPTH, default 4, pending-free FIFO depth; power of two, at least 2.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 reqAlloc  in  1  client alloc request; accepted when reqAlloc && reqAllocReady.
REQ-006 reqAllocReady  out  1  high when no alloc is pending or in flight.
REQ-007 allocValid  out  1  one-cycle pulse: allocAddr holds a newly allocated address.
REQ-008 allocAddr  out  ADDR_BITS  last allocated address, held until the next allocValid.
REQ-009 reqFree  in  1  client free request; accepted when reqFree && reqFreeReady.
REQ-010 reqFreeAddr  in  ADDR_BITS  address to free, sampled on acceptance.
REQ-011 reqFreeReady  out  1  high when the free FIFO is not full.
REQ-012 heapAlloc  out  1  alloc strobe to the heap, registered.
REQ-013 heapFree  out  1  free strobe to the heap, registered.
REQ-014 heapFreeAddress  out  ADDR_BITS  address being freed.
REQ-015 heapAllocAddress  in  ADDR_BITS  heap result, valid while heapFinished is high.
REQ-016 heapFinished  in  1  heap operation complete.
REQ-017 liveCount  out  ADDR_BITS+1  number of allocations minus number of frees completed.
REQ-018 freeUnderflow  out  1  sticky flag: a free completed while liveCount was 0.

Function
REQ-019 The block SHALL use an FSM with the states IDLE, WAIT_ALLOC and WAIT_FREE.
REQ-020 An accepted alloc SHALL set allocPending; an accepted free SHALL push reqFreeAddr into the FIFO in the same edge.
REQ-021 Grant in IDLE, alloc only: if allocPending is set, the block SHALL go to WAIT_ALLOC.
REQ-022 Grant in IDLE, free only: if the FIFO is non-empty, the block SHALL go to WAIT_FREE.
REQ-023 Grant in IDLE, both pending: the block SHALL alternate using lastGrant, which resets to alloc, so the first contested grant is a free.
REQ-024 Entering WAIT_ALLOC SHALL assert heapAlloc for exactly one cycle.
REQ-025 Entering WAIT_FREE SHALL pop the FIFO head into heapFreeAddress and assert heapFree for exactly one cycle.
REQ-026 heapFreeAddress SHALL stay stable until heapFinished is seen.
REQ-027 heapAlloc and heapFree SHALL never be high together, and neither SHALL be high outside the first wait cycle.
REQ-028 heapFinished in WAIT_ALLOC SHALL capture heapAllocAddress into allocAddr, clear allocPending, increment liveCount and return to IDLE.
REQ-029 allocValid SHALL pulse on the cycle after the capture in REQ-028.
REQ-030 heapFinished in WAIT_FREE SHALL decrement liveCount, saturating at 0, and return to IDLE.
REQ-031 If liveCount is 0 at the completion in REQ-030, freeUnderflow SHALL be set and stay set until reset.
REQ-032 heapFinished in IDLE SHALL be ignored.
REQ-033 No timeout: the block SHALL wait indefinitely in WAIT_*.
REQ-034 A FIFO push and pop in the same cycle SHALL both take effect.
REQ-035 A push while the FIFO is full is blocked by reqFreeReady, even if a pop happens in the same cycle.
REQ-036 FIFO pointers SHALL wrap modulo FREE_DEPTH.
REQ-037 The next grant SHALL be evaluated in the IDLE cycle after a completion, giving a minimum of 3 cycles between heap strobes.

Reset
REQ-038 Reset SHALL force the following values: state IDLE, FIFO empty, allocPending 0, lastGrant alloc.
REQ-039 Reset SHALL force all outputs to 0, except reqAllocReady = 1 and reqFreeReady = 1.
REQ-040 Reset mid-operation SHALL abandon any in-flight request with no allocValid; the heap is reset by the same reset.

Structure
REQ-041 ADDRESS_BITS SHALL come from defaults.vh; FSM state encodings SHALL be local parameters.
REQ-042 The pending-free FIFO SHALL be a sub-module, heap_free_fifo (parameters ADDR_BITS and FREE_DEPTH; ports push, pop, full, empty, head).

Verification
REQ-043 Alloc: reqAlloc after reset -> heapAlloc pulses 1 cycle; heap returns heapFinished with heapAllocAddress 0x00 -> allocValid 1 cycle, allocAddr 0x00, liveCount 1.
REQ-044 Free: free 0x10 with liveCount 1 -> heapFree pulses 1 cycle, heapFreeAddress 0x10 held 2 cycles until heapFinished -> liveCount 0, freeUnderflow 0.
REQ-045 Contention: alloc and free 0x20 accepted in the same cycle -> free issued first, then alloc, with no overlapping strobes.
REQ-046 FIFO full: heapFinished held low, 6 back-to-back frees -> first goes in flight, 4 more accepted, 6th blocked with reqFreeReady 0.
REQ-047 Underflow: free 0x05 with liveCount 0 -> freeUnderflow 1 and stays 1; liveCount stays 0.
REQ-048 Reset mid-op: reset during WAIT_ALLOC -> all outputs return to reset values, no allocValid, FIFO empty.
